// File: rtl/sa_ctrl_pkg.sv
// Shared types and helpers for the output-stationary systolic array sequencer.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  // Drain length: buffer latency, lane skew, array propagation, PE register.
  function automatic int flush_len(input int n, input int pe_lat);
    return 1 + 2 * (n - 1) + pe_lat;
  endfunction

  function automatic int lane_lsb(input int z, input int width);
    return z * width;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage zero-reset shift register for one lane; DEPTH=0 is a plain wire.
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused_clk;
    assign w_unused_clk = i_clk & i_rst_n;
    assign o_q = i_d;
  end else begin : g_reg
    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_q = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/sa_os_sequencer.sv
// Job sequencer for an N x N output-stationary MAC array: clear, feed K skewed vectors, drain.
// y_valid rises 1+K+F cycles after an accepted start and holds until y_ready.
module sa_os_sequencer
  import sa_ctrl_pkg::*;
#(
  parameter int N      = 8,
  parameter int WIDTH  = 8,
  parameter int K_W    = 12,
  parameter int PE_LAT = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [K_W-1:0]     k_len,
  output logic               busy,
  output logic               rd_en,
  output logic [K_W-1:0]     rd_addr,
  input  logic [N*WIDTH-1:0] a_vec,
  input  logic [N*WIDTH-1:0] b_vec,
  output logic [N*WIDTH-1:0] AA,
  output logic [N*WIDTH-1:0] BB,
  output logic               arr_clr,
  output logic               y_valid,
  input  logic               y_ready
);

  localparam int F    = flush_len(N, PE_LAT);
  localparam int FC_W = $clog2(F + 1);
  // The FLUSH->DONE register transition supplies the last drain cycle.
  localparam logic [FC_W-1:0] FC_LAST = FC_W'((F > 1) ? F - 2 : 0);

  state_t          r_state, w_next;
  logic [K_W-1:0]  r_k;
  logic [K_W-1:0]  r_addr;
  logic [FC_W-1:0] r_fcnt;
  logic            r_lvld;
  logic [K_W-1:0]  w_k_last;

  assign w_k_last = r_k - K_W'(1);
  assign rd_addr  = r_addr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_addr  <= '0;
      r_fcnt  <= '0;
      r_lvld  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_lvld  <= rd_en;
      if (r_state == S_IDLE && start) r_k <= k_len;
      case (r_state)
        S_CLEAR: begin
          r_addr <= '0;
          r_fcnt <= '0;
        end
        S_FEED:  if (r_addr != w_k_last) r_addr <= r_addr + K_W'(1);
        S_FLUSH: r_fcnt <= r_fcnt + FC_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    busy    = 1'b1;
    rd_en   = 1'b0;
    arr_clr = 1'b0;
    y_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        arr_clr = 1'b1;
        w_next  = (r_k == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        rd_en = 1'b1;
        if (r_addr == w_k_last) w_next = S_FLUSH;
      end
      S_FLUSH: if (r_fcnt == FC_LAST) w_next = S_DONE;
      S_DONE: begin
        y_valid = 1'b1;
        if (y_ready) w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Lanes are gated to zero before the skew so bubbles carry no stale operands.
  for (genvar z = 0; z < N; z++) begin : g_lane
    logic [WIDTH-1:0] w_a_in, w_b_in;
    assign w_a_in = r_lvld ? a_vec[lane_lsb(z, WIDTH) +: WIDTH] : '0;
    assign w_b_in = r_lvld ? b_vec[lane_lsb(z, WIDTH) +: WIDTH] : '0;

    sa_skew_line #(.DEPTH(z), .WIDTH(WIDTH)) u_skew_a (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_d     (w_a_in),
      .o_q     (AA[lane_lsb(z, WIDTH) +: WIDTH])
    );

    sa_skew_line #(.DEPTH(z), .WIDTH(WIDTH)) u_skew_b (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_d     (w_b_in),
      .o_q     (BB[lane_lsb(z, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_sa_os_sequencer.sv
// Directed bench: N=4 sequencer for control timing, N=8 sequencer for lane skew.
module tb_sa_os_sequencer;

  localparam int W  = 8;
  localparam int KW = 12;
  localparam int F4 = 8;
  localparam int F8 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s4, yr4, busy4, rden4, clr4, yv4;
  logic [KW-1:0] k4, addr4;
  logic [4*W-1:0] a4, b4, aa4, bb4;

  logic          s8, yr8, busy8, rden8, clr8, yv8;
  logic [KW-1:0] k8, addr8;
  logic [8*W-1:0] a8, b8, aa8, bb8;

  int checks = 0;
  int errors = 0;

  sa_os_sequencer #(.N(4), .WIDTH(W), .K_W(KW), .PE_LAT(1)) u_dut4 (
    .CLK(clk), .RST(rst_n), .start(s4), .k_len(k4), .busy(busy4), .rd_en(rden4),
    .rd_addr(addr4), .a_vec(a4), .b_vec(b4), .AA(aa4), .BB(bb4), .arr_clr(clr4),
    .y_valid(yv4), .y_ready(yr4)
  );

  sa_os_sequencer #(.N(8), .WIDTH(W), .K_W(KW), .PE_LAT(1)) u_dut8 (
    .CLK(clk), .RST(rst_n), .start(s8), .k_len(k8), .busy(busy8), .rd_en(rden8),
    .rd_addr(addr8), .a_vec(a8), .b_vec(b8), .AA(aa8), .BB(bb8), .arr_clr(clr8),
    .y_valid(yv8), .y_ready(yr8)
  );

  // Operand buffers: data one cycle after rd_en, 0xFF garbage otherwise.
  always @(posedge clk) begin
    for (int z = 0; z < 4; z++) begin
      a4[z*W +: W] <= rden4 ? 8'(16 + z) : 8'hFF;
      b4[z*W +: W] <= rden4 ? 8'h01 : 8'hFF;
    end
    for (int z = 0; z < 8; z++) begin
      a8[z*W +: W] <= rden8 ? 8'(1 + z) : 8'hFF;
      b8[z*W +: W] <= rden8 ? 8'(32 + z) : 8'hFF;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          st;
    logic          yr;
    logic          bsy;
    logic          clr;
    logic          rd;
    logic [KW-1:0] addr;
    logic [7:0]    aa0;
    logic [7:0]    aa3;
    logic [7:0]    bb3;
    logic          yv;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit yr, input bit bsy, input bit clr,
                              input bit rd, input int addr, input int aa0, input int aa3,
                              input int bb3, input bit yv);
    vec_t v;
    v.st = st; v.yr = yr; v.bsy = bsy; v.clr = clr; v.rd = rd;
    v.addr = KW'(addr); v.aa0 = 8'(aa0); v.aa3 = 8'(aa3); v.bb3 = 8'(bb3); v.yv = yv;
    return v;
  endfunction

  // One N=4 job from IDLE with y_ready high; checks clear, feed, zero-pad and latency.
  task automatic timed_job(input int k, input string tag);
    int clr_c = -1, n_clr = 0, first_rd = -1, rd_n = 0, yv_c = -1, nz = 0;
    yr4 = 1'b1;
    k4  = KW'(k);
    s4  = 1'b1;
    for (int c = 0; c < 80 && yv_c < 0; c++) begin
      if (c == 1) s4 = 1'b0;
      if (clr4) begin
        n_clr++;
        if (clr_c < 0) clr_c = c;
      end
      if (rden4) begin
        if (first_rd < 0) first_rd = c;
        check({tag, "_rd_addr"}, 64'(addr4), 64'(c - first_rd));
        rd_n++;
      end
      if ((aa4 | bb4) != '0) nz++;
      if (yv4) yv_c = c;
      tick();
    end
    check({tag, "_clr_cycle"}, 64'(clr_c), 64'(1));
    check({tag, "_clr_count"}, 64'(n_clr), 64'(1));
    check({tag, "_first_rd"}, 64'(first_rd), (k > 0) ? 64'(2) : 64'(-1));
    check({tag, "_rd_count"}, 64'(rd_n), 64'(k));
    check({tag, "_lane_nz_cycles"}, 64'(nz), (k > 0) ? 64'(k + 3) : 64'(0));
    check({tag, "_yv_cycle"}, 64'(yv_c), (k > 0) ? 64'(1 + k + F4) : 64'(2));
  endtask

  vec_t tbl[14];
  logic [8*W-1:0] hist_a [40];
  logic [8*W-1:0] hist_b [40];

  initial begin
    int clr1, clr2, yv1, yv2, nclr, nyv, bsy11, stray, yv8c;
    logic [7:0] exp_l0, exp_a, exp_b;

    s4 = 1'b0; yr4 = 1'b0; k4 = '0;
    s8 = 1'b0; yr8 = 1'b0; k8 = '0;

    #1;
    check("rst_busy", 64'(busy4), 64'(0));
    check("rst_rd_en", 64'(rden4), 64'(0));
    check("rst_rd_addr", 64'(addr4), 64'(0));
    check("rst_AA", 64'(aa4), 64'(0));
    check("rst_BB", 64'(bb4), 64'(0));
    check("rst_arr_clr", 64'(clr4), 64'(0));
    check("rst_y_valid", 64'(yv4), 64'(0));
    check("rst8_AA", aa8, 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // N=4, K=3 reference job, cycle 0 = start sampled.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 'h00, 'h00, 'h00, 0);
    tbl[1]  = mk(0, 0, 1, 1, 0, 0, 'h00, 'h00, 'h00, 0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 0, 'h00, 'h00, 'h00, 0);
    tbl[3]  = mk(0, 0, 1, 0, 1, 1, 'h10, 'h00, 'h00, 0);
    tbl[4]  = mk(0, 0, 1, 0, 1, 2, 'h10, 'h00, 'h00, 0);
    tbl[5]  = mk(0, 0, 1, 0, 0, 2, 'h10, 'h00, 'h00, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0, 2, 'h00, 'h13, 'h01, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 2, 'h00, 'h13, 'h01, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 2, 'h00, 'h13, 'h01, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 2, 'h00, 'h00, 'h00, 0);
    tbl[10] = mk(0, 0, 1, 0, 0, 2, 'h00, 'h00, 'h00, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 2, 'h00, 'h00, 'h00, 0);
    tbl[12] = mk(0, 1, 1, 0, 0, 2, 'h00, 'h00, 'h00, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 2, 'h00, 'h00, 'h00, 0);

    k4 = KW'(3);
    for (int i = 0; i < 14; i++) begin
      s4  = tbl[i].st;
      yr4 = tbl[i].yr;
      check($sformatf("k3_c%0d_busy", i), 64'(busy4), 64'(tbl[i].bsy));
      check($sformatf("k3_c%0d_arr_clr", i), 64'(clr4), 64'(tbl[i].clr));
      check($sformatf("k3_c%0d_rd_en", i), 64'(rden4), 64'(tbl[i].rd));
      check($sformatf("k3_c%0d_rd_addr", i), 64'(addr4), 64'(tbl[i].addr));
      check($sformatf("k3_c%0d_AA0", i), 64'(aa4[7:0]), 64'(tbl[i].aa0));
      check($sformatf("k3_c%0d_AA3", i), 64'(aa4[31:24]), 64'(tbl[i].aa3));
      check($sformatf("k3_c%0d_BB3", i), 64'(bb4[31:24]), 64'(tbl[i].bb3));
      check($sformatf("k3_c%0d_y_valid", i), 64'(yv4), 64'(tbl[i].yv));
      tick();
    end

    timed_job(0, "k0");

    // y_valid held while y_ready low; starts in DONE and in the handshake cycle are ignored.
    yr4 = 1'b0; k4 = KW'(1); s4 = 1'b1;
    tick();
    s4 = 1'b0;
    for (int c = 0; c < 40 && !yv4; c++) tick();
    check("hold_reach_done", 64'(yv4), 64'(1));
    for (int c = 0; c < 5; c++) begin
      s4 = (c == 2);
      check($sformatf("hold%0d_y_valid", c), 64'(yv4), 64'(1));
      check($sformatf("hold%0d_busy", c), 64'(busy4), 64'(1));
      check($sformatf("hold%0d_arr_clr", c), 64'(clr4), 64'(0));
      tick();
    end
    check("hold_end_y_valid", 64'(yv4), 64'(1));
    yr4 = 1'b1; s4 = 1'b1;
    tick();
    s4 = 1'b0; yr4 = 1'b0;
    check("hs_busy_next", 64'(busy4), 64'(0));
    check("hs_y_valid_next", 64'(yv4), 64'(0));
    tick();
    check("hs_start_ignored", 64'(busy4), 64'(0));
    check("hs_no_clr", 64'(clr4), 64'(0));

    // Reset in the middle of FEED.
    k4 = KW'(10); s4 = 1'b1;
    tick();
    s4 = 1'b0;
    repeat (5) tick();
    check("midfeed_rd_addr", 64'(addr4), 64'(4));
    check("midfeed_AA_live", 64'(aa4 != '0), 64'(1));
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy4), 64'(0));
    check("arst_rd_en", 64'(rden4), 64'(0));
    check("arst_rd_addr", 64'(addr4), 64'(0));
    check("arst_AA", 64'(aa4), 64'(0));
    check("arst_BB", 64'(bb4), 64'(0));
    check("arst_arr_clr", 64'(clr4), 64'(0));
    check("arst_y_valid", 64'(yv4), 64'(0));
    tick();
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      if (yv4 || busy4) stray++;
      tick();
    end
    check("arst_no_resume", 64'(stray), 64'(0));
    timed_job(2, "post_rst_k2");

    // Back-to-back jobs with start and y_ready held high.
    clr1 = -1; clr2 = -1; yv1 = -1; yv2 = -1; nclr = 0; nyv = 0; bsy11 = -1;
    yr4 = 1'b1; k4 = KW'(1); s4 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) k4 = KW'(4);
      if (c == 12) s4 = 1'b0;
      if (clr4) begin
        nclr++;
        if (clr1 < 0) clr1 = c; else if (clr2 < 0) clr2 = c;
      end
      if (yv4) begin
        nyv++;
        if (yv1 < 0) yv1 = c; else if (yv2 < 0) yv2 = c;
      end
      if (c == 11) bsy11 = int'(busy4);
      tick();
    end
    check("b2b_clr_count", 64'(nclr), 64'(2));
    check("b2b_yv_count", 64'(nyv), 64'(2));
    check("b2b_clr1", 64'(clr1), 64'(1));
    check("b2b_yv1", 64'(yv1), 64'(1 + 1 + F4));
    check("b2b_gap_idle", 64'(bsy11), 64'(0));
    check("b2b_clr2", 64'(clr2), 64'(12));
    check("b2b_yv2", 64'(yv2), 64'(12 + 4 + F4));
    yr4 = 1'b0;

    // N=8 skew: lane z must be lane 0 delayed z cycles, carrying its own value.
    yv8c = -1;
    yr8 = 1'b1; k8 = KW'(5); s8 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 1) s8 = 1'b0;
      hist_a[c] = aa8;
      hist_b[c] = bb8;
      if (yv8 && yv8c < 0) yv8c = c;
      tick();
    end
    check("n8_yv_cycle", 64'(yv8c), 64'(1 + 5 + F8));
    for (int c = 0; c < 40; c++) begin
      exp_l0 = (c >= 3 && c < 8) ? 8'd1 : 8'd0;
      check($sformatf("n8_c%0d_lane0", c), 64'(hist_a[c][7:0]), 64'(exp_l0));
      for (int z = 1; z < 8; z++) begin
        exp_a = 8'd0;
        exp_b = 8'd0;
        if (c >= z && hist_a[c-z][7:0] != 8'd0) begin
          exp_a = 8'(z + 1);
          exp_b = 8'(32 + z);
        end
        check($sformatf("n8_c%0d_AA%0d", c, z), 64'(hist_a[c][z*W +: W]), 64'(exp_a));
        check($sformatf("n8_c%0d_BB%0d", c, z), 64'(hist_b[c][z*W +: W]), 64'(exp_b));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
